// File: rtl/out_port_buffer_pkg.sv
// Shared definitions for the output-port buffer: default sizes and the
// occupancy-counter width helper used by the FIFO.
package out_port_buffer_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int OUT_FIFO_DEPTH = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_port_buffer_sync_fifo.sv
// Single-clock FIFO with registered head. The pointers wrap modulo DEPTH.
// The count holds the occupancy, and full and empty are decoded from it.
// The head is read straight from storage, so a pushed word becomes visible
// one edge after the push. A word never falls through in the same cycle.
module sync_fifo
  import out_port_buffer_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = OUT_FIFO_DEPTH,
  parameter  int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;
  logic              full_w;
  logic              empty_w;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Qualify requests: no pop from empty; push into full only alongside a pop.
  always_comb begin
    pop_ok  = pop & ~empty_w;
    push_ok = push & (~full_w | pop_ok);
  end

  // Next storage contents: write the incoming word at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
    end
  end

  // Next pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the queue and zeroes storage so the head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_w;
  assign empty = empty_w;

endmodule

// File: rtl/out_port_buffer.sv
// Output-port buffer fed by the datapath OUT instruction. It detects the
// rising edge of OutPortin and captures the bus word once per assertion.
// The block keeps the legacy OutPort holding register. It queues captured
// words and hands them to the device over a valid/ready handshake. A capture
// into a full queue is dropped and flagged with a sticky overflow bit.
module out_port_buffer
  import out_port_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = OUT_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              OutPortin,
  input  logic [DATA_W-1:0] BusMuxOut,
  output logic [DATA_W-1:0] OutPort_out,
  output logic              dev_valid,
  output logic [DATA_W-1:0] dev_data,
  input  logic              dev_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow
);

  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              overflow_q, overflow_d;
  logic              cap;
  logic              pop;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [ADDR_W:0]   fifo_count;

  // Capture decode: one capture per strobe assertion, and a pop frees a slot for a push in the same cycle.
  always_comb begin
    cap  = OutPortin & ~strobe_q;
    pop  = ~fifo_empty & dev_ready;
    push = cap & (~fifo_full | pop);
    drop = cap & fifo_full & ~pop;
  end

  // Next holding-register, strobe-history and overflow values; a drop outranks a clear.
  always_comb begin
    strobe_d   = OutPortin;
    out_port_d = out_port_q;
    overflow_d = overflow_q;
    if (cap) begin
      out_port_d = BusMuxOut;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Control and holding registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      strobe_q   <= 1'b0;
      out_port_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q   <= strobe_d;
      out_port_q <= out_port_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .pop   (pop),
    .din   (BusMuxOut),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign OutPort_out = out_port_q;
  assign dev_valid   = ~fifo_empty;
  assign dev_data    = fifo_head;
  assign full        = fifo_full;
  assign empty       = fifo_empty;
  assign count       = fifo_count;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_out_port_buffer.sv
// Bench for out_port_buffer. A queue-based reference model tracks the
// expected queue contents, holding register and overflow flag. Directed
// steps are followed by a randomized run.
module tb_out_port_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          OutPortin;
  logic [DW-1:0] BusMuxOut;
  logic [DW-1:0] OutPort_out;
  logic          dev_valid;
  logic [DW-1:0] dev_data;
  logic          dev_ready;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_overflow;

  out_port_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .OutPortin    (OutPortin),
    .BusMuxOut    (BusMuxOut),
    .OutPort_out  (OutPort_out),
    .dev_valid    (dev_valid),
    .dev_data     (dev_data),
    .dev_ready    (dev_ready),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic          m_prev;
  logic [DW-1:0] m_out;
  logic [DW-1:0] dut_rx[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    m_out  = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(mq.size()));
    chk({tag, "_valid"}, 64'(dev_valid), 64'(mq.size() != 0));
    chk({tag, "_full"}, 64'(full), 64'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_outport"}, 64'(OutPort_out), 64'(m_out));
    if (mq.size() != 0) chk({tag, "_head"}, 64'(dev_data), 64'(mq[0]));
  endtask

  // One clock cycle: drive inputs, advance the model, clock the DUT, compare.
  task automatic step(input logic s, input logic [DW-1:0] bus, input logic rdy,
                      input logic clr, input string tag);
    logic          cap;
    logic          drop;
    logic [DW-1:0] tmp;
    OutPortin    = s;
    BusMuxOut    = bus;
    dev_ready    = rdy;
    clr_overflow = clr;
    #1;
    if (dev_valid && dev_ready) dut_rx.push_back(dev_data);
    cap  = s && !m_prev;
    drop = 1'b0;
    if (mq.size() != 0 && rdy) tmp = mq.pop_front();
    if (cap) begin
      m_out = bus;
      if (mq.size() < DEPTH) mq.push_back(bus);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = s;
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  task automatic strobe(input logic [DW-1:0] v, input logic rdy, input string tag);
    step(1'b1, v, rdy, 1'b0, tag);
    step(1'b0, '0, rdy, 1'b0, tag);
  endtask

  initial begin
    Reset        = 1'b0;
    OutPortin    = 1'b0;
    BusMuxOut    = '0;
    dev_ready    = 1'b0;
    clr_overflow = 1'b0;
    model_reset();
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(dev_valid), 64'd0);
    chk("rst_data", 64'(dev_data), 64'd0);
    chk("rst_outport", 64'(OutPort_out), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, "idle");

    // Held strobe captures once
    step(1'b1, 32'h0000_00A5, 1'b0, 1'b0, "t2a");
    chk("t2_valid_first", 64'(dev_valid), 64'd1);
    chk("t2_data_first", 64'(dev_data), 64'h0000_00A5);
    step(1'b1, 32'h0000_00A5, 1'b0, 1'b0, "t2b");
    step(1'b1, 32'h0000_00A5, 1'b0, 1'b0, "t2c");
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_outport", 64'(OutPort_out), 64'h0000_00A5);
    step(1'b0, '0, 1'b0, 1'b0, "t2d");

    // Asynchronous reset with two words queued
    strobe(32'h0000_00B6, 1'b0, "t1_fill");
    chk("t1_pre_count", 64'(count), 64'd2);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    chk("t1_valid", 64'(dev_valid), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_outport", 64'(OutPort_out), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_data", 64'(dev_data), 64'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "t1_post");
    chk("t1_post_empty", 64'(empty), 64'd1);

    // Fill, overflow on the fifth, then drain in order
    for (int v = 1; v <= 5; v++) strobe(DW'(v), 1'b0, "t3_fill");
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_outport", 64'(OutPort_out), 64'd5);
    dut_rx.delete();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "t3_drain");
    chk("t3_rx_n", 64'(dut_rx.size()), 64'd4);
    for (int i = 0; i < 4 && i < dut_rx.size(); i++)
      chk("t3_rx", 64'(dut_rx[i]), 64'(i + 1));
    chk("t3_empty", 64'(empty), 64'd1);

    // Push into full queue with a simultaneous pop
    step(1'b0, '0, 1'b0, 1'b1, "t4_clr");
    for (int v = 10; v <= 13; v++) strobe(DW'(v), 1'b0, "t4_fill");
    dut_rx.delete();
    step(1'b1, 32'd14, 1'b1, 1'b0, "t4_pp");
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_ovf", 64'(overflow), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, "t4_idle");
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "t4_drain");
    chk("t4_rx_n", 64'(dut_rx.size()), 64'd5);
    for (int i = 0; i < 5 && i < dut_rx.size(); i++)
      chk("t4_rx", 64'(dut_rx[i]), 64'(10 + i));

    // Set beats clear
    for (int v = 20; v <= 23; v++) strobe(DW'(v), 1'b0, "t5_fill");
    strobe(32'd24, 1'b0, "t5_drop");
    chk("t5_ovf_set", 64'(overflow), 64'd1);
    step(1'b1, 32'd25, 1'b0, 1'b1, "t5_drop_clr");
    chk("t5_ovf_hold", 64'(overflow), 64'd1);
    chk("t5_outport", 64'(OutPort_out), 64'd25);
    step(1'b0, '0, 1'b0, 1'b1, "t5_clr");
    chk("t5_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "t5_drain");

    // Pointer wrap with toggling ready
    dut_rx.delete();
    begin
      logic rdy;
      rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
        step(1'b1, DW'(32'h100 + i), rdy, 1'b0, "t6_push");
        rdy = ~rdy;
        step(1'b0, '0, rdy, 1'b0, "t6_gap");
        rdy = ~rdy;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, "t6_drain");
    chk("t6_rx_n", 64'(dut_rx.size()), 64'd9);
    for (int i = 0; i < 9 && i < dut_rx.size(); i++)
      chk("t6_rx", 64'(dut_rx[i]), 64'(32'h100 + i));
    chk("t6_ovf", 64'(overflow), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic rdy;
      if (i < 200) rdy = ($urandom_range(0, 3) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), DW'($urandom), rdy,
           1'($urandom_range(0, 7) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
